controlador_ascensor: RTL and testbench

- Single-car elevator controller FSM. Turns floor-request pulses into the car-state signals that the display and LED controllers consume: piso, direccion and puertas_abiertas.
- Replaces the fixed-sequence test stimulus modules (one instance per car) in the top level.
- Services pending requests collectively: keeps its current travel direction while requests remain ahead, then reverses.

---
 rtl/controlador_ascensor_pkg.sv | 39 +++
 rtl/controlador_ascensor_if.sv | 18 +
 rtl/controlador_ascensor_contador_tiempo.sv | 29 ++
 rtl/controlador_ascensor.sv | 153 +++++++++++++++
 tb/tb_controlador_ascensor.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/controlador_ascensor_pkg.sv
// Shared types and helpers for the single-car elevator controller.
package ascensor_pkg;

  localparam int NUM_PISOS = 4;

  localparam logic [1:0] DIR_PARADO = 2'b00;
  localparam logic [1:0] DIR_SUBE   = 2'b01;
  localparam logic [1:0] DIR_BAJA   = 2'b10;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTAS  = 2'd3
  } estado_t;

  function automatic logic hay_arriba(input logic [NUM_PISOS-1:0] mascara, input logic [1:0] piso);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_PISOS; i++) begin
      r = r | (mascara[i] & (i > int'(piso)));
    end
    return r;
  endfunction

  function automatic logic hay_abajo(input logic [NUM_PISOS-1:0] mascara, input logic [1:0] piso);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_PISOS; i++) begin
      r = r | (mascara[i] & (i < int'(piso)));
    end
    return r;
  endfunction

  function automatic logic [NUM_PISOS-1:0] un_piso(input logic [1:0] piso);
    return 4'b0001 << piso;
  endfunction

endpackage

// File: rtl/controlador_ascensor_if.sv
// Request and car-state signals between the controller and its consumers.
interface controlador_ascensor_if;
  logic [3:0] solicitud;
  logic [1:0] piso;
  logic [1:0] direccion;
  logic       puertas_abiertas;
  logic [3:0] pendientes;

  modport master (
    output solicitud,
    input  piso, direccion, puertas_abiertas, pendientes
  );

  modport slave (
    input  solicitud,
    output piso, direccion, puertas_abiertas, pendientes
  );
endinterface

// File: rtl/controlador_ascensor_contador_tiempo.sv
// Loadable down-counter; expira pulses for one cycle on the last count.
module contador_tiempo #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carga,
  input  logic [ANCHO-1:0] valor,
  output logic             expira
);

  logic [ANCHO-1:0] cuenta_r;

  // Count down to zero, reloading on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta_r <= '0;
    end else if (carga) begin
      cuenta_r <= valor;
    end else if (cuenta_r != '0) begin
      cuenta_r <= cuenta_r - ANCHO'(1);
    end else begin
      cuenta_r <= cuenta_r;
    end
  end

  assign expira = (cuenta_r == ANCHO'(1));

endmodule

// File: rtl/controlador_ascensor.sv
// Collective-service elevator FSM: sweeps in one direction while requests remain ahead.
module controlador_ascensor
  import ascensor_pkg::*;
#(
  parameter int T_VIAJE  = 50_000_000,
  parameter int T_PUERTA = 100_000_000
) (
  input logic                    clk,
  input logic                    rst,
  controlador_ascensor_if.slave  bus
);

  localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] CARGA_VIAJE  = TW'(T_VIAJE);
  localparam logic [TW-1:0] CARGA_PUERTA = TW'(T_PUERTA);

  estado_t        estado_r, estado_sig_s;
  logic [1:0]     piso_r, piso_sig_s, piso_llegada_s, piso_base_s;
  logic [1:0]     direccion_r;
  logic           puertas_r;
  logic           sentido_r, sentido_sig_s;
  logic [3:0]     pendientes_r, pend_sig_s, limpiar_s, ignorar_s;
  logic [3:0]     solicitud_s;
  logic           carga_s, expira_s;
  logic [TW-1:0]  valor_s;
  logic           arriba_s, abajo_s, subir_s, bajar_s;

  contador_tiempo #(.ANCHO(TW)) u_tiempo (
    .clk    (clk),
    .rst    (rst),
    .carga  (carga_s),
    .valor  (valor_s),
    .expira (expira_s)
  );

  assign solicitud_s    = bus.solicitud;
  assign piso_llegada_s = (estado_r == BAJANDO) ? (piso_r - 2'd1) : (piso_r + 2'd1);
  // While moving, decisions are taken relative to the floor being reached this edge.
  assign piso_base_s    = ((estado_r == SUBIENDO) || (estado_r == BAJANDO)) ? piso_llegada_s : piso_r;
  assign arriba_s       = hay_arriba(pendientes_r, piso_base_s);
  assign abajo_s        = hay_abajo(pendientes_r, piso_base_s);
  assign subir_s        = arriba_s & (sentido_r | ~abajo_s);
  assign bajar_s        = abajo_s & ~subir_s;
  assign pend_sig_s     = (pendientes_r | solicitud_s) & ~ignorar_s & ~limpiar_s;

  // Next-state, timer load and pending-mask updates.
  always_comb begin
    estado_sig_s  = estado_r;
    piso_sig_s    = piso_r;
    sentido_sig_s = sentido_r;
    carga_s       = 1'b0;
    valor_s       = CARGA_VIAJE;
    limpiar_s     = 4'b0000;
    ignorar_s     = 4'b0000;
    case (estado_r)
      REPOSO: begin
        if (pendientes_r[piso_r]) begin
          estado_sig_s = PUERTAS;
          carga_s      = 1'b1;
          valor_s      = CARGA_PUERTA;
          limpiar_s    = un_piso(piso_r);
        end else if (arriba_s) begin
          estado_sig_s  = SUBIENDO;
          sentido_sig_s = 1'b1;
          carga_s       = 1'b1;
        end else if (abajo_s) begin
          estado_sig_s  = BAJANDO;
          sentido_sig_s = 1'b0;
          carga_s       = 1'b1;
        end else begin
          estado_sig_s = REPOSO;
        end
      end
      SUBIENDO, BAJANDO: begin
        if (expira_s) begin
          piso_sig_s = piso_llegada_s;
          carga_s    = 1'b1;
          if (pendientes_r[piso_llegada_s]) begin
            estado_sig_s = PUERTAS;
            valor_s      = CARGA_PUERTA;
            limpiar_s    = un_piso(piso_llegada_s);
          end else if (subir_s) begin
            estado_sig_s  = SUBIENDO;
            sentido_sig_s = 1'b1;
          end else if (bajar_s) begin
            estado_sig_s  = BAJANDO;
            sentido_sig_s = 1'b0;
          end else begin
            estado_sig_s = REPOSO;
            carga_s      = 1'b0;
          end
        end else begin
          estado_sig_s = estado_r;
        end
      end
      PUERTAS: begin
        // A call for the open floor only keeps the doors open longer.
        ignorar_s = un_piso(piso_r);
        if (solicitud_s[piso_r]) begin
          carga_s = 1'b1;
          valor_s = CARGA_PUERTA;
        end else if (expira_s) begin
          if (subir_s) begin
            estado_sig_s  = SUBIENDO;
            sentido_sig_s = 1'b1;
            carga_s       = 1'b1;
          end else if (bajar_s) begin
            estado_sig_s  = BAJANDO;
            sentido_sig_s = 1'b0;
            carga_s       = 1'b1;
          end else begin
            estado_sig_s = REPOSO;
          end
        end else begin
          estado_sig_s = PUERTAS;
        end
      end
      default: begin
        estado_sig_s = REPOSO;
      end
    endcase
  end

  // State and registered car outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r     <= REPOSO;
      piso_r       <= 2'd0;
      sentido_r    <= 1'b1;
      pendientes_r <= 4'b0000;
      puertas_r    <= 1'b0;
      direccion_r  <= DIR_PARADO;
    end else begin
      estado_r     <= estado_sig_s;
      piso_r       <= piso_sig_s;
      sentido_r    <= sentido_sig_s;
      pendientes_r <= pend_sig_s;
      puertas_r    <= (estado_sig_s == PUERTAS);
      case (estado_sig_s)
        SUBIENDO: direccion_r <= DIR_SUBE;
        BAJANDO:  direccion_r <= DIR_BAJA;
        default:  direccion_r <= DIR_PARADO;
      endcase
    end
  end

  assign bus.piso             = piso_r;
  assign bus.direccion        = direccion_r;
  assign bus.puertas_abiertas = puertas_r;
  assign bus.pendientes       = pendientes_r;

endmodule

// File: tb/tb_controlador_ascensor.sv
// Directed bench for controlador_ascensor with T_VIAJE=4, T_PUERTA=3.
module tb_controlador_ascensor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pruebas = 0;
  int   fallos = 0;
  int   n = 0;
  logic vio11 = 1'b0;

  controlador_ascensor_if bus_if ();

  controlador_ascensor #(.T_VIAJE(4), .T_PUERTA(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    pruebas++;
    if (obs !== esp) begin
      fallos++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, esp, n);
    end
  endtask

  // n counts edges since reset release; outputs are sampled 1 time unit after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (bus_if.direccion === 2'b11) vio11 = 1'b1;
  endtask

  task automatic hasta(input int k);
    while (n < k) tick();
  endtask

  task automatic estado(input string tag, input logic [1:0] p, input logic [1:0] d,
                        input logic pa, input logic [3:0] pe);
    chequear({tag, ".piso"}, 32'(bus_if.piso), 32'(p));
    chequear({tag, ".dir"},  32'(bus_if.direccion), 32'(d));
    chequear({tag, ".pa"},   32'(bus_if.puertas_abiertas), 32'(pa));
    chequear({tag, ".pend"}, 32'(bus_if.pendientes), 32'(pe));
  endtask

  task automatic reiniciar();
    rst = 1'b1;
    bus_if.solicitud = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
  endtask

  task automatic pedir(input logic [3:0] m);
    bus_if.solicitud = m;
    tick();
    bus_if.solicitud = 4'b0000;
  endtask

  initial begin
    bus_if.solicitud = 4'b0000;

    // Reset state, then idle with no requests.
    reiniciar();
    estado("rst", 2'd0, 2'b00, 1'b0, 4'b0000);
    hasta(20);
    estado("idle", 2'd0, 2'b00, 1'b0, 4'b0000);

    // Single request to floor 3.
    reiniciar();
    pedir(4'b1000);
    estado("a1", 2'd0, 2'b00, 1'b0, 4'b1000);
    hasta(2);  estado("a2", 2'd0, 2'b01, 1'b0, 4'b1000);
    hasta(5);  chequear("a5.piso", 32'(bus_if.piso), 32'd0);
    hasta(6);  estado("a6", 2'd1, 2'b01, 1'b0, 4'b1000);
    hasta(10); estado("a10", 2'd2, 2'b01, 1'b0, 4'b1000);
    hasta(14); estado("a14", 2'd3, 2'b00, 1'b1, 4'b0000);
    hasta(16); chequear("a16.pa", 32'(bus_if.puertas_abiertas), 32'd1);
    hasta(17); estado("a17", 2'd3, 2'b00, 1'b0, 4'b0000);
    hasta(20); estado("a20", 2'd3, 2'b00, 1'b0, 4'b0000);

    // Reset asserted while travelling at floor 2.
    reiniciar();
    pedir(4'b1000);
    hasta(11); estado("r11", 2'd2, 2'b01, 1'b0, 4'b1000);
    rst = 1'b1;
    tick();
    estado("rmid", 2'd0, 2'b00, 1'b0, 4'b0000);
    rst = 1'b0;

    // Intermediate stop at floor 1 on the way up.
    reiniciar();
    pedir(4'b1000);
    hasta(3);
    pedir(4'b0010);
    hasta(6);  estado("b6", 2'd1, 2'b00, 1'b1, 4'b1000);
    hasta(8);  chequear("b8.pa", 32'(bus_if.puertas_abiertas), 32'd1);
    hasta(9);  estado("b9", 2'd1, 2'b01, 1'b0, 4'b1000);
    hasta(17); estado("b17", 2'd3, 2'b00, 1'b1, 4'b0000);
    hasta(20); estado("b20", 2'd3, 2'b00, 1'b0, 4'b0000);

    // Floor 0 requested while going up waits for the reverse sweep.
    reiniciar();
    pedir(4'b1000);
    hasta(3);
    pedir(4'b0001);
    hasta(10); estado("c10", 2'd2, 2'b01, 1'b0, 4'b1001);
    hasta(14); estado("c14", 2'd3, 2'b00, 1'b1, 4'b0001);
    hasta(17); estado("c17", 2'd3, 2'b10, 1'b0, 4'b0001);
    hasta(21); estado("c21", 2'd2, 2'b10, 1'b0, 4'b0001);
    hasta(29); estado("c29", 2'd0, 2'b00, 1'b1, 4'b0000);
    hasta(32); estado("c32", 2'd0, 2'b00, 1'b0, 4'b0000);

    // Request at the current floor, then re-request while doors are open.
    reiniciar();
    pedir(4'b0001);
    estado("d1", 2'd0, 2'b00, 1'b0, 4'b0001);
    tick();
    estado("d2", 2'd0, 2'b00, 1'b1, 4'b0000);
    hasta(3);
    pedir(4'b0001);
    estado("d4", 2'd0, 2'b00, 1'b1, 4'b0000);
    hasta(5); chequear("d5.pa", 32'(bus_if.puertas_abiertas), 32'd1);
    hasta(6); chequear("d6.pa", 32'(bus_if.puertas_abiertas), 32'd1);
    hasta(7); estado("d7", 2'd0, 2'b00, 1'b0, 4'b0000);

    // Idle at floor 1 with requests above and below: up first.
    reiniciar();
    pedir(4'b0010);
    hasta(9);  estado("e9", 2'd1, 2'b00, 1'b0, 4'b0000);
    pedir(4'b1001);
    estado("e10", 2'd1, 2'b00, 1'b0, 4'b1001);
    hasta(11); estado("e11", 2'd1, 2'b01, 1'b0, 4'b1001);
    hasta(19); estado("e19", 2'd3, 2'b00, 1'b1, 4'b0001);
    hasta(22); estado("e22", 2'd3, 2'b10, 1'b0, 4'b0001);
    hasta(34); estado("e34", 2'd0, 2'b00, 1'b1, 4'b0000);
    hasta(37); estado("e37", 2'd0, 2'b00, 1'b0, 4'b0000);

    chequear("dir_nunca_11", 32'(vio11), 32'd0);

    $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
    $finish;
  end

endmodule
